binary_bcd_seq: RTL
===================

# binary_bcd_seq

Multi-cycle binary-to-BCD converter built around a per-digit add-3 correction datapath, one correction cell per BCD digit. A start/done handshake lets an upstream block submit a WIDTH-bit binary value. The converter returns DIGITS packed BCD digits WIDTH+1 clock edges later. It feeds display and readout paths that need decimal digits from a binary counter or register.

## Interface
- WIDTH, 8: binary input width in bits; must be ≥ 1.
- DIGITS, 3: number of BCD output digits; must be ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- bin  in  WIDTH  binary operand; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd is valid and updated.
- bcd  out  4*DIGITS  packed result; digit 0 in bits [3:0]; holds its value until the next done.
- ovf  out  1  result exceeded 10^DIGITS−1 (see Configuration); qualified by done, held with bcd.

## Operation
- State machine:
  - IDLE -> SHIFT on start=1.
  - SHIFT -> SHIFT while the bit counter is > 0.
  - SHIFT -> DONE when the counter reaches 0.
  - DONE -> IDLE unconditionally.
- On acceptance in IDLE:
  - shift register ← bin;
  - BCD working register ← 0;
  - counter ← WIDTH;
  - busy ← 1.
- Each SHIFT cycle, in order:
  - every working digit ≥ 5 gets +3 (mod 16);
  - the working register {BCD, shift} shifts left by one; the shift MSB enters BCD bit 0;
  - counter decrements.
- The bit shifted out of the top of the BCD working register is the overflow carry (see Configuration).
- Entering DONE:
  - bcd ← working register;
  - ovf ← sticky overflow;
  - done = 1 for exactly that cycle;
  - busy stays 1 through DONE.
- Arithmetic: digit correction is 4-bit only, with no inter-digit carry. On overflow, bcd = bin mod 10^DIGITS.
- start while busy (SHIFT or DONE) is ignored, not queued. bin changes after acceptance have no effect.
- Reset values: state IDLE, busy=0, done=0, bcd=0, ovf=0, counter=0, working registers=0.
- rst mid-conversion aborts it: no done pulse; bcd returns to 0.
- rst and start high on the same edge: rst wins, and start is not accepted.

## Timing
- Edge E0 accepts start; busy reads 1 from E0 onward.
- Shifts occur on edges E1..E_WIDTH.
- E_WIDTH+1 loads bcd/ovf and raises done for one cycle.
- Latency, start-accept edge to done: WIDTH+1 edges.
- At E_WIDTH+2: busy=0, done=0.
- Earliest next accept is E_WIDTH+2 (start held high). Throughput is one conversion per WIDTH+2 cycles.
- done and busy are registered outputs with no combinational path from start.

## Configuration
- Macro BINARY_BCD_SEQ_OVF_EN.
- Defined:
  - a sticky flag clears on accept;
  - it sets on any SHIFT edge where a 1 leaves the top BCD digit;
  - it is copied to ovf at DONE.
- Undefined:
  - no flag logic;
  - the ovf port is still present and tied to 0;
  - bcd still returns bin mod 10^DIGITS.

## Test plan
- WIDTH=8, DIGITS=3; bin=8'd0, start pulse -> done 9 edges after accept; bcd=12'h000, ovf=0.
- bin=8'd255 -> bcd=12'h255. bin=8'd99 -> 12'h099. bin=8'd128 -> 12'h128. Each with done exactly one cycle wide.
- start re-asserted during SHIFT with bin=8'd7 while converting 8'd200 -> bcd=12'h200; no second done.
- rst asserted 4 edges into a conversion of 8'd173 -> busy=0, bcd=0 next cycle, no done. A fresh start with 8'd173 -> 12'h173.
- start held high continuously with bin=8'd42 -> done every 10 cycles, bcd=12'h042 each time.
- DIGITS=2 with BINARY_BCD_SEQ_OVF_EN defined: bin=8'd200 -> bcd=8'h00, ovf=1. Then bin=8'd57 -> bcd=8'h57, ovf=0. Without the macro: ovf=0 for both.

Source files
------------

// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 with one correction cell per digit.
// Optional overflow flag logic is enabled with the BINARY_BCD_SEQ_OVF_EN macro.
module binary_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
    logic [BW-1:0]    work_r;
    logic [BW-1:0]    work_s;
    logic [BW-1:0]    corr_s;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [BW-1:0]    bcd_r;

    // Add-3 correction for one digit; wraps mod 16, no carry into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Per-digit correction followed by the one-bit left shift of {work, shift}.
    always_comb begin
        corr_s = {BW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            corr_s[4*i +: 4] = add3(work_r[4*i +: 4]);
        end
        work_s  = {corr_s[BW-2:0], shift_r[WIDTH-1]};
        shift_s = shift_r << 1;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working registers, bit counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= {WIDTH{1'b0}};
            work_r  <= {BW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            bcd_r   <= {BW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r <= bin;
                        work_r  <= {BW{1'b0}};
                        cnt_r   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    shift_r <= shift_s;
                    work_r  <= work_s;
                    cnt_r   <= cnt_r - CW'(1);
                end
                DONE: begin
                    bcd_r <= work_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // busy covers accept through the done cycle; done marks the cycle after the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_r != IDLE) || start;
            done_r <= (state_r == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

`ifdef BINARY_BCD_SEQ_OVF_EN
    logic flag_r;
    logic ovf_r;

    // Sticky flag catches any 1 shifted out of the top digit during a conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        flag_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (corr_s[BW-1]) begin
                        flag_r <= 1'b1;
                    end
                end
                DONE: begin
                    ovf_r <= flag_r;
                end
                default: begin
                    flag_r <= 1'b0;
                end
            endcase
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule
